e_md_ctrl: RTL and testbench
============================

// Module: e_md_ctrl
// PURPOSE
//  E-stage multiply/divide sequencer. Owns the HI/LO registers and sequences multi-cycle mult/div.
//  Serves mthi/mtlo/mfhi/mflo. Exports busy/start so the stall unit can hold D-stage md instrs.
//  Sits beside E_ALU. Operands are the forwarded rs/rt of E; result feeds the E->M pipeline register.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (and madd family); legal 1..15
//  DIV_CYCLES   10  busy cycles for div/divu; legal 1..15
// PORTS
//  clk      in   1   clock, rising edge
//  reset    in   1   asynchronous, active-low; clears HI/LO/FSM
//  md_op    in   4   E-stage op, `MD_* codes (NONE,MULT,MULTU,DIV,DIVU,MTHI,MTLO,MFHI,MFLO[,MADD..])
//  rs       in   32  forwarded rs operand
//  rt       in   32  forwarded rt operand
//  start    out  1   combinational: md_op is a multi-cycle op and FSM is IDLE
//  busy     out  1   registered: FSM in RUN
//  hilo_out out  32  HI for MFHI, LO for MFLO, else 0 (combinational, committed HI/LO)
// BEHAVIOUR
//  - Reset (async, any time incl. mid-operation): hi=0, lo=0, state=IDLE, cnt=0, pending regs=0.
//    Outputs: busy=0; start/hilo_out follow md_op.
//  - FSM IDLE: on edge with start=1, latch result into hi_pend/lo_pend from rs/rt of that cycle.
//    Then load cnt=latency-1 and go to RUN.
//  - FSM RUN: cnt decrements each edge. On the edge where cnt==0: hi<=hi_pend, lo<=lo_pend, go IDLE.
//  - Timing: op accepted at edge k -> busy=1 for exactly N cycles (N=MULT_CYCLES/DIV_CYCLES).
//    New HI/LO visible after edge k+N, same edge busy falls.
//  - MULT/MULTU: {hi,lo} = signed/unsigned 32x32->64 product.
//  - DIV/DIVU: lo=quotient, hi=remainder, signed truncates toward zero (remainder sign = dividend).
//  - Divide by zero: full DIV_CYCLES busy, HI/LO unchanged at completion.
//  - Special case: 0x80000000 / -1 -> lo=0x80000000, hi=0.
//  - MTHI/MTLO while IDLE: hi/lo <= rs at the next edge, no busy.
//  - MFHI/MFLO: hilo_out combinational from committed hi/lo; value-in-flight is not visible.
//  - Any md_op other than NONE while busy=1 is illegal; the stall unit prevents it.
//    The block ignores it (no state change) and the bench asserts it never occurs.
//  - md_op of multi-cycle op in same cycle busy falls: not possible (busy still 1); accepted next cycle.
//  - Unknown op codes behave as NONE.
// CONFIGURATION
//  MD_MADD_EN defined: adds MADD/MADDU/MSUB/MSUBU.
//    {hi,lo}_pend = {hi,lo} +/- product, using committed hi/lo at accept. Latency MULT_CYCLES; start=1.
//  MD_MADD_EN undefined: those codes decode as NONE, start=0, no state change.
// STRUCTURE
//  - `MD_* op codes and `MD_LAT_W counter width go in const.v, next to the `RFWD_*/ALU codes.
//    _CU and _SU use these codes.
//  - One sub-module: md_calc (combinational). Inputs: op, rs, rt, hi, lo. Output: {hi_next, lo_next}.
//    It handles the signed/unsigned product and quotient, plus the div-by-0 and overflow cases.
//  - e_md_ctrl keeps the FSM, counter, pending regs and HI/LO.
// TESTING
//  - MULT rs=0xFFFFFFFF rt=2 -> busy 5 cycles; then hi=0xFFFFFFFF lo=0xFFFFFFFE.
//    MULTU same operands -> hi=1 lo=0xFFFFFFFE.
//  - DIV rs=-7 rt=2 -> busy 10 cycles; then lo=0xFFFFFFFD hi=0xFFFFFFFF.
//    DIVU rs=7 rt=2 -> lo=3 hi=1.
//  - MTHI rs=0x12345678 -> hi=0x12345678 next cycle, busy=0.
//    Then MFHI -> hilo_out=0x12345678. Then DIVU rt=0 -> HI/LO unchanged after 10 cycles.
//  - Start DIV, drop reset low in RUN cycle 4 -> busy=0, hi=lo=0 immediately.
//    Release reset -> IDLE. A new MULT completes normally.
//  - Back-to-back: MULT, then MULTU presented while busy -> ignored.
//    Re-presented the cycle after busy falls -> accepted, completes 5 cycles later.
//  - (MD_MADD_EN) hi=0 lo=0xFFFFFFFF, MADDU rs=1 rt=1 -> hi=1 lo=0.
//    Without the macro, the same op -> start=0, no change.

Source files
------------

// File: rtl/e_md_ctrl_pkg.sv
// Shared op codes and helpers for the E-stage multiply/divide sequencer.
// Optional feature macro: MD_MADD_EN (adds MADD/MADDU/MSUB/MSUBU).
package e_md_ctrl_pkg;

  localparam int unsigned MD_LAT_W = 4;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;
  localparam logic [3:0] MD_MADD  = 4'd9;
  localparam logic [3:0] MD_MADDU = 4'd10;
  localparam logic [3:0] MD_MSUB  = 4'd11;
  localparam logic [3:0] MD_MSUBU = 4'd12;

  // Ops that take the multiplier latency
  function automatic logic md_is_mul(input logic [3:0] op);
`ifdef MD_MADD_EN
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) ||
           (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`else
    return (op == MD_MULT) || (op == MD_MULTU);
`endif
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_md_ctrl_md_calc.sv
// Combinational HI/LO result generator for mult/div (and optional madd family).
// Optional feature macro: MD_MADD_EN.
module md_calc
  import e_md_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] hilo_next
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, divisor;
  logic [31:0] q_u, r_u;

  // Products, quotients and remainders for every op; op selects below
  always_comb begin
    // Low 64 bits of the product of sign-extended operands equal the signed product
    prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    prod_u = {32'b0, rs} * {32'b0, rt};

    // Divisor forced to 1 on zero so no X/undefined value is ever produced
    divisor = (rt == '0) ? 32'd1 : rt;
    q_u     = rs / divisor;
    r_u     = rs % divisor;

    // Signed divide on magnitudes; 0x80000000 / -1 falls out as lo=0x80000000, hi=0
    a_mag = rs[31] ? (32'd0 - rs) : rs;
    b_mag = rt[31] ? (32'd0 - divisor) : divisor;
    q_mag = a_mag / b_mag;
    r_mag = a_mag % b_mag;

    hilo_next = {hi, lo};
    case (op)
      MD_MULT:  hilo_next = prod_s;
      MD_MULTU: hilo_next = prod_u;
      MD_DIV: if (rt != '0) begin
        hilo_next[31:0]  = (rs[31] ^ rt[31]) ? (32'd0 - q_mag) : q_mag;
        hilo_next[63:32] = rs[31] ? (32'd0 - r_mag) : r_mag;
      end
      MD_DIVU: if (rt != '0) hilo_next = {r_u, q_u};
`ifdef MD_MADD_EN
      MD_MADD:  hilo_next = {hi, lo} + prod_s;
      MD_MADDU: hilo_next = {hi, lo} + prod_u;
      MD_MSUB:  hilo_next = {hi, lo} - prod_s;
      MD_MSUBU: hilo_next = {hi, lo} - prod_u;
`endif
      default:  hilo_next = {hi, lo};
    endcase
  end

endmodule

// File: rtl/e_md_ctrl.sv
// E-stage multiply/divide sequencer: HI/LO ownership, multi-cycle busy sequencing,
// mthi/mtlo/mfhi/mflo service. Optional feature macro: MD_MADD_EN.
module e_md_ctrl
  import e_md_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        start,
  output logic        busy,
  output logic [31:0] hilo_out
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t              state_q;
  logic [MD_LAT_W-1:0] cnt_q, cnt_d;
  logic [31:0]         hi_q, lo_q;
  logic [31:0]         hi_pend_q, lo_pend_q;
  logic [31:0]         hi_pend_d, lo_pend_d;
  logic                busy_q;

  md_calc u_calc (
    .op        (md_op),
    .rs        (rs),
    .rt        (rt),
    .hi        (hi_q),
    .lo        (lo_q),
    .hilo_next ({hi_pend_d, lo_pend_d})
  );

  // Accept decode, initial countdown and read-back mux
  always_comb begin
    start = (md_is_mul(md_op) || md_is_div(md_op)) && (state_q == S_IDLE);
    cnt_d = md_is_div(md_op) ? MD_LAT_W'(DIV_CYCLES - 1) : MD_LAT_W'(MULT_CYCLES - 1);
    case (md_op)
      MD_MFHI: hilo_out = hi_q;
      MD_MFLO: hilo_out = lo_q;
      default: hilo_out = '0;
    endcase
  end

  assign busy = busy_q;

  // Sequencer: latch result on accept, count down, commit HI/LO as busy drops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      hi_pend_q <= '0;
      lo_pend_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            hi_pend_q <= hi_pend_d;
            lo_pend_q <= lo_pend_d;
            cnt_q     <= cnt_d;
            state_q   <= S_RUN;
            busy_q    <= 1'b1;
          end else if (md_op == MD_MTHI) begin
            hi_q <= rs;
          end else if (md_op == MD_MTLO) begin
            lo_q <= rs;
          end
        end
        S_RUN: begin
          if (cnt_q == '0) begin
            hi_q    <= hi_pend_q;
            lo_q    <= lo_pend_q;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - MD_LAT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_e_md_ctrl.sv
// Directed self-checking bench for e_md_ctrl (MULT_CYCLES=5, DIV_CYCLES=10).
module tb_e_md_ctrl;
  import e_md_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] rs, rt;
  logic        start, busy;
  logic [31:0] hilo_out;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          allow_illegal = 1'b0;

  e_md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .md_op    (md_op),
    .rs       (rs),
    .rt       (rt),
    .start    (start),
    .busy     (busy),
    .hilo_out (hilo_out)
  );

  always #5 clk = ~clk;

  // The stall unit must never present an op while busy
  always @(negedge clk) begin
    if (reset === 1'b1 && !allow_illegal && busy === 1'b1) begin
      n_cmp++;
      if (md_op !== MD_NONE) begin
        n_bad++;
        $display("FAIL op_while_busy: md_op=%0d expected %0d", md_op, MD_NONE);
      end
    end
  end

  // Present op for one edge (called at posedge+1)
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op = op; rs = a; rt = b;
    @(posedge clk); #1;
    md_op = MD_NONE;
  endtask

  // Count cycles until busy falls, bounded
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic read_hilo(input logic [3:0] op, output logic [31:0] v);
    md_op = op; #1;
    v = hilo_out;
    md_op = MD_NONE;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b0; md_op = MD_NONE; rs = '0; rt = '0;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
    md_op = MD_MULT; #1;
    n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL rst_start: got %b expected 1", start); end
    read_hilo(MD_MFHI, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL rst_hi: got %h expected 0", v); end
    read_hilo(MD_MFLO, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL rst_lo: got %h expected 0", v); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    logic [31:0] v;
    int n;
    md_op = MD_MULT; rs = 32'hFFFF_FFFF; rt = 32'd2; #1;
    n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL mult_start: got %b expected 1", start); end
    @(posedge clk); #1; md_op = MD_NONE;
    allow_illegal = 1'b1;
    read_hilo(MD_MFLO, v);
    allow_illegal = 1'b0;
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL mult_inflight: got %h expected 0", v); end
    wait_idle(n);
    n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL mult_busy: got %0d expected 5", n); end
    read_hilo(MD_MFHI, v);
    n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_hi: got %h expected ffffffff", v); end
    read_hilo(MD_MFLO, v);
    n_cmp++; if (v !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL mult_lo: got %h expected fffffffe", v); end

    @(posedge clk); #1;
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL multu_busy: got %0d expected 5", n); end
    read_hilo(MD_MFHI, v);
    n_cmp++; if (v !== 32'h1) begin n_bad++; $display("FAIL multu_hi: got %h expected 1", v); end
    read_hilo(MD_MFLO, v);
    n_cmp++; if (v !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_lo: got %h expected fffffffe", v); end
  endtask

  task automatic test_div();
    logic [31:0] v;
    int n;
    logic [31:0] vec_a  [4] = '{32'hFFFF_FFF9, 32'd7,        32'h8000_0000, 32'd7};
    logic [31:0] vec_b  [4] = '{32'd2,        32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd2};
    logic [3:0]  vec_op [4] = '{MD_DIV,       MD_DIV,       MD_DIV,        MD_DIVU};
    logic [31:0] exp_lo [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'd3};
    logic [31:0] exp_hi [4] = '{32'hFFFF_FFFF, 32'd1,        32'd0,         32'd1};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      issue(vec_op[i], vec_a[i], vec_b[i]);
      wait_idle(n);
      n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL div%0d_busy: got %0d expected 10", i, n); end
      read_hilo(MD_MFLO, v);
      n_cmp++; if (v !== exp_lo[i]) begin n_bad++; $display("FAIL div%0d_lo: got %h expected %h", i, v, exp_lo[i]); end
      read_hilo(MD_MFHI, v);
      n_cmp++; if (v !== exp_hi[i]) begin n_bad++; $display("FAIL div%0d_hi: got %h expected %h", i, v, exp_hi[i]); end
    end
  endtask

  task automatic test_mt_divzero();
    logic [31:0] v;
    int n;
    @(posedge clk); #1;
    md_op = MD_MTHI; rs = 32'h1234_5678; #1;
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL mthi_start: got %b expected 0", start); end
    @(posedge clk); #1; md_op = MD_NONE;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mthi_busy: got %b expected 0", busy); end
    read_hilo(MD_MFHI, v);
    n_cmp++; if (v !== 32'h1234_5678) begin n_bad++; $display("FAIL mfhi: got %h expected 12345678", v); end
    @(posedge clk); #1;
    issue(MD_DIVU, 32'd5, 32'd0);
    wait_idle(n);
    n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL div0_busy: got %0d expected 10", n); end
    read_hilo(MD_MFHI, v);
    n_cmp++; if (v !== 32'h1234_5678) begin n_bad++; $display("FAIL div0_hi: got %h expected 12345678", v); end
    read_hilo(MD_MFLO, v);
    n_cmp++; if (v !== 32'd3) begin n_bad++; $display("FAIL div0_lo: got %h expected 3", v); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    int n;
    @(posedge clk); #1;
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    read_hilo(MD_MFHI, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL midrst_hi: got %h expected 0", v); end
    read_hilo(MD_MFLO, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL midrst_lo: got %h expected 0", v); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    issue(MD_MULT, 32'd3, 32'd4);
    wait_idle(n);
    n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL postrst_busy: got %0d expected 5", n); end
    read_hilo(MD_MFLO, v);
    n_cmp++; if (v !== 32'd12) begin n_bad++; $display("FAIL postrst_lo: got %h expected c", v); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    int n;
    @(posedge clk); #1;
    issue(MD_MULT, 32'd5, 32'd6);
    allow_illegal = 1'b1;
    md_op = MD_MULTU; rs = 32'd7; rt = 32'd8; #1;
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL b2b_start_busy: got %b expected 0", start); end
    wait_idle(n);
    allow_illegal = 1'b0;
    n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL b2b_first_busy: got %0d expected 5", n); end
    read_hilo(MD_MFLO, v);
    n_cmp++; if (v !== 32'd30) begin n_bad++; $display("FAIL b2b_first_lo: got %h expected 1e", v); end
    md_op = MD_MULTU; #1;
    n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL b2b_start_idle: got %b expected 1", start); end
    @(posedge clk); #1; md_op = MD_NONE;
    wait_idle(n);
    n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL b2b_second_busy: got %0d expected 5", n); end
    read_hilo(MD_MFLO, v);
    n_cmp++; if (v !== 32'd56) begin n_bad++; $display("FAIL b2b_second_lo: got %h expected 38", v); end
  endtask

  task automatic test_madd();
    logic [31:0] v;
    int n;
    logic [31:0] exp_hi, exp_lo;
    @(posedge clk); #1;
    issue(MD_MTHI, 32'h0, 32'h0);
    issue(MD_MTLO, 32'hFFFF_FFFF, 32'h0);
    md_op = MD_MADDU; rs = 32'd1; rt = 32'd1; #1;
`ifdef MD_MADD_EN
    n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL maddu_start: got %b expected 1", start); end
    @(posedge clk); #1; md_op = MD_NONE;
    wait_idle(n);
    n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL maddu_busy: got %0d expected 5", n); end
    exp_hi = 32'd1; exp_lo = 32'd0;
`else
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL maddu_start: got %b expected 0", start); end
    @(posedge clk); #1; md_op = MD_NONE;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL maddu_busy: got %b expected 0", busy); end
    exp_hi = 32'd0; exp_lo = 32'hFFFF_FFFF;
`endif
    read_hilo(MD_MFHI, v);
    n_cmp++; if (v !== exp_hi) begin n_bad++; $display("FAIL maddu_hi: got %h expected %h", v, exp_hi); end
    read_hilo(MD_MFLO, v);
    n_cmp++; if (v !== exp_lo) begin n_bad++; $display("FAIL maddu_lo: got %h expected %h", v, exp_lo); end
    // Unknown code behaves as NONE
    @(posedge clk); #1;
    md_op = 4'hF; rs = 32'hDEAD_BEEF; #1;
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL unk_start: got %b expected 0", start); end
    @(posedge clk); #1; md_op = MD_NONE;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL unk_busy: got %b expected 0", busy); end
    read_hilo(MD_MFLO, v);
    n_cmp++; if (v !== exp_lo) begin n_bad++; $display("FAIL unk_lo: got %h expected %h", v, exp_lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt_divzero();
    test_reset_mid();
    test_back_to_back();
    test_madd();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
